// File: rtl/term_loopback_pkg.sv
// Shared types and helpers for the edge-terminal loopback matrix.
package term_loopback_pkg;

  typedef enum logic [1:0] {
    WM_DIRECT = 2'b00,
    WM_REG    = 2'b01,
    WM_LOW    = 2'b10,
    WM_HIGH   = 2'b11
  } wire_mode_t;

  // Source index of wire i after reversal within its group of w wires.
  function automatic int rev_idx(input int i, input int w);
    return (i / w) * w + (w - 1 - (i % w));
  endfunction

endpackage

// File: rtl/term_cfg_chain.sv
// Serial shadow chain, load counter and active config register with commit status pulses.
module term_cfg_chain
  import term_loopback_pkg::*;
#(
  parameter int CFG_BITS = 96
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                cfg_din_i,
  input  logic                cfg_shift_i,
  input  logic                cfg_commit_i,
  output logic [CFG_BITS-1:0] active_o,
  output logic                cfg_dout_o,
  output logic                cfg_done_o,
  output logic                cfg_err_o
);

  localparam int CNT_W = $clog2(CFG_BITS + 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(CFG_BITS);

  logic [CFG_BITS-1:0] sr_q, sr_d;
  logic [CFG_BITS-1:0] active_q, active_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                done_q, done_d;
  logic                err_q, err_d;

  // Commit takes priority over a coincident shift; that cycle's data bit is dropped.
  always_comb begin
    sr_d     = sr_q;
    active_d = active_q;
    cnt_d    = cnt_q;
    done_d   = 1'b0;
    err_d    = 1'b0;
    if (cfg_commit_i) begin
      cnt_d = '0;
      if (cnt_q == CNT_FULL) begin
        active_d = sr_q;
        done_d   = 1'b1;
      end else begin
        err_d = 1'b1;
      end
    end else if (cfg_shift_i) begin
      sr_d = {sr_q[CFG_BITS-2:0], cfg_din_i};
      if (cnt_q != CNT_FULL) begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sr_q     <= '0;
      active_q <= '0;
      cnt_q    <= '0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      sr_q     <= sr_d;
      active_q <= active_d;
      cnt_q    <= cnt_d;
      done_q   <= done_d;
      err_q    <= err_d;
    end
  end

  assign active_o   = active_q;
  assign cfg_dout_o = sr_q[CFG_BITS-1];
  assign cfg_done_o = done_q;
  assign cfg_err_o  = err_q;

endmodule

// File: rtl/term_loopback_matrix.sv
// Edge terminal: loops END wires back to BEG wires, reversed within each group,
// with a per-wire programmable direct / registered / tied-low / tied-high mode.
module term_loopback_matrix
  import term_loopback_pkg::*;
#(
  parameter  int GROUP_W    = 8,
  parameter  int NUM_GROUPS = 6,
  localparam int N          = GROUP_W * NUM_GROUPS,
  localparam int CFG_BITS   = 2 * N
) (
  input  logic         UserCLK,
  input  logic         RESET,
  input  logic [N-1:0] end_i,
  output logic [N-1:0] beg_o,
  input  logic         cfg_din_i,
  input  logic         cfg_shift_i,
  input  logic         cfg_commit_i,
  output logic         cfg_dout_o,
  output logic         cfg_done_o,
  output logic         cfg_err_o
);

  logic [N-1:0]        rev;
  logic [N-1:0]        pipe_q;
  logic [CFG_BITS-1:0] active;

  term_cfg_chain #(
    .CFG_BITS(CFG_BITS)
  ) u_cfg (
    .clk_i       (UserCLK),
    .rst_i       (RESET),
    .cfg_din_i   (cfg_din_i),
    .cfg_shift_i (cfg_shift_i),
    .cfg_commit_i(cfg_commit_i),
    .active_o    (active),
    .cfg_dout_o  (cfg_dout_o),
    .cfg_done_o  (cfg_done_o),
    .cfg_err_o   (cfg_err_o)
  );

  // The pipe runs every cycle so switching a wire into registered mode is glitch-free.
  always_ff @(posedge UserCLK or posedge RESET) begin
    if (RESET) begin
      pipe_q <= '0;
    end else begin
      pipe_q <= rev;
    end
  end

  for (genvar i = 0; i < N; i++) begin : g_wire
    localparam int RI = rev_idx(i, GROUP_W);
    logic beg;

    assign rev[i]   = end_i[RI];
    assign beg_o[i] = beg;

    always_comb begin
      beg = rev[i];
      case (wire_mode_t'(active[2*i +: 2]))
        WM_DIRECT: beg = rev[i];
        WM_REG:    beg = pipe_q[i];
        WM_LOW:    beg = 1'b0;
        WM_HIGH:   beg = 1'b1;
        default:   beg = rev[i];
      endcase
    end
  end

endmodule
